qgemm_acc_lane: RTL and testbench



---
 rtl/qgemm_pkg.sv | 24 ++
 rtl/qgemm_acc_lane_if.sv | 32 +++
 rtl/qgemm_sat_add.sv | 30 +++
 rtl/qgemm_acc_lane.sv | 123 ++++++++++++
 tb/tb_qgemm_acc_lane.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qgemm_pkg.sv
// Purpose: shared types and constants for the quantized GEMM accumulator lane.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: lane FSM state enum, default-width saturation bounds, product width.
package qgemm_pkg;

  localparam int BIT_NUM_DEF = 8;
  localparam int ACC_W_DEF   = 32;

  // A full signed product of two BIT_NUM operands needs exactly 2*BIT_NUM bits,
  // including the (-2^(n-1))^2 corner case.
  localparam int PROD_W = 2 * BIT_NUM_DEF;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/qgemm_acc_lane_if.sv
// Purpose: config / operand / result handshake bundle of one accumulator lane.
// Latency: n/a (wires only).
// Backpressure: cfg_ready, op_ready and res_ready carry the flow control.
// Modports: master = job source and result sink, slave = the lane itself.
interface qgemm_acc_lane_if #(
  parameter int BIT_NUM = 8,
  parameter int ACC_W   = 32,
  parameter int LEN_W   = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [LEN_W-1:0]   cfg_len;
  logic               op_valid;
  logic               op_ready;
  logic [BIT_NUM-1:0] op_a;
  logic [BIT_NUM-1:0] op_b;
  logic               res_valid;
  logic               res_ready;
  logic [ACC_W-1:0]   res_acc;
  logic               res_sat;
  logic               busy;

  modport master (
    output cfg_valid, cfg_len, op_valid, op_a, op_b, res_ready,
    input  cfg_ready, op_ready, res_valid, res_acc, res_sat, busy
  );

  modport slave (
    input  cfg_valid, cfg_len, op_valid, op_a, op_b, res_ready,
    output cfg_ready, op_ready, res_valid, res_acc, res_sat, busy
  );
endinterface

// File: rtl/qgemm_sat_add.sv
// Purpose: combinational signed saturating add of a product into an accumulator.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: acc_i (ACC_W signed), add_i (PROD_W signed) -> sum_o (clamped), sat_flag_o.
module qgemm_sat_add #(
  parameter int ACC_W  = 32,
  parameter int PROD_W = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] add_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              sat_flag_o
);

  localparam int EXT_W = ACC_W + 1 - PROD_W;

  // One guard bit is enough: |acc| + |addend| never exceeds 2^ACC_W when PROD_W <= ACC_W.
  logic [ACC_W:0] wide;
  assign wide = {acc_i[ACC_W-1], acc_i} + {{EXT_W{add_i[PROD_W-1]}}, add_i};

  always_comb begin
    sat_flag_o = wide[ACC_W] ^ wide[ACC_W-1];
    sum_o      = wide[ACC_W-1:0];
    if (sat_flag_o) begin
      // Guard bit holds the true sign: 0 means positive overflow.
      sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/qgemm_acc_lane.sv
// Purpose: signed dot-product accumulator for one GEMM output element.
// Latency: result valid 2 cycles after the last operand beat (1 cycle after start if K=0).
// Backpressure: result held while res_ready low; operands only taken in RUN, config only in IDLE.
// Ports: clk, rstnn (async active-low), lane (slave modport: cfg / op / res handshakes, busy).
module qgemm_acc_lane
  import qgemm_pkg::*;
#(
  parameter int BIT_NUM = 8,
  parameter int ACC_W   = 32,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              rstnn,
  qgemm_acc_lane_if.slave   lane
);

  localparam int PW = 2 * BIT_NUM;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [PW-1:0]      p_q, p_d;
  logic               p_vld_q, p_vld_d;

  logic signed [PW-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]     add_sum;
  logic                 add_sat;

  // Operands are widened before the multiply so the product is the exact signed result.
  assign a_ext = {{BIT_NUM{lane.op_a[BIT_NUM-1]}}, lane.op_a};
  assign b_ext = {{BIT_NUM{lane.op_b[BIT_NUM-1]}}, lane.op_b};
  assign prod  = a_ext * b_ext;

  qgemm_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PW)
  ) u_sat_add (
    .acc_i      (acc_q),
    .add_i      (p_q),
    .sum_o      (add_sum),
    .sat_flag_o (add_sat)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    p_d     = p_q;
    p_vld_d = 1'b0;

    // Product stage drains independently of the FSM; it is only ever set in RUN,
    // so it cannot collide with the accumulator clear on start.
    if (p_vld_q) begin
      acc_d = add_sum;
      sat_d = sat_q | add_sat;
    end

    case (state_q)
      ST_IDLE: begin
        if (lane.cfg_valid) begin
          len_d   = lane.cfg_len;
          cnt_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = (lane.cfg_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (lane.op_valid) begin
          p_d     = prod;
          p_vld_d = 1'b1;
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (lane.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
    end
  end

  assign lane.cfg_ready = (state_q == ST_IDLE);
  assign lane.op_ready  = (state_q == ST_RUN);
  assign lane.res_valid = (state_q == ST_DONE);
  assign lane.busy      = (state_q != ST_IDLE);
  assign lane.res_acc   = acc_q;
  assign lane.res_sat   = sat_q;

endmodule

// File: tb/tb_qgemm_acc_lane.sv
// Purpose: self-checking bench for qgemm_acc_lane at ACC_W=32 and ACC_W=16 side by side.
// Latency: checks result timing relative to the last operand beat and the start handshake.
// Backpressure: exercises held results, ignored cfg/op pulses and mid-job async reset.
module tb_qgemm_acc_lane;

  logic clk;
  logic rstnn;

  logic        cfg_valid;
  logic [15:0] cfg_len;
  logic        op_valid;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        res_ready;

  int total;
  int bad;

  qgemm_acc_lane_if #(.BIT_NUM(8), .ACC_W(32), .LEN_W(16)) if32 ();
  qgemm_acc_lane_if #(.BIT_NUM(8), .ACC_W(16), .LEN_W(16)) if16 ();

  // Both lanes see identical stimulus; only their accumulator width differs.
  assign if32.cfg_valid = cfg_valid;
  assign if32.cfg_len   = cfg_len;
  assign if32.op_valid  = op_valid;
  assign if32.op_a      = op_a;
  assign if32.op_b      = op_b;
  assign if32.res_ready = res_ready;
  assign if16.cfg_valid = cfg_valid;
  assign if16.cfg_len   = cfg_len;
  assign if16.op_valid  = op_valid;
  assign if16.op_a      = op_a;
  assign if16.op_b      = op_b;
  assign if16.res_ready = res_ready;

  qgemm_acc_lane #(.BIT_NUM(8), .ACC_W(32), .LEN_W(16)) dut32 (
    .clk   (clk),
    .rstnn (rstnn),
    .lane  (if32)
  );

  qgemm_acc_lane #(.BIT_NUM(8), .ACC_W(16), .LEN_W(16)) dut16 (
    .clk   (clk),
    .rstnn (rstnn),
    .lane  (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     k;
    int     a[8];
    int     b[8];
    bit     gap;
    int     hold;
    longint e32;
    bit     s32;
    longint e16;
    bit     s16;
  } vec_t;

  vec_t vecs[7];
  int   cur_a[16];
  int   cur_b[16];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum with clamping after each product.
  task automatic model(input int w, input int k, output longint acc, output bit sat);
    longint mx, mn;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -mx - 1;
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < k; i++) begin
      acc = acc + longint'(cur_a[i]) * longint'(cur_b[i]);
      if (acc > mx) begin
        acc = mx;
        sat = 1'b1;
      end else if (acc < mn) begin
        acc = mn;
        sat = 1'b1;
      end
    end
  endtask

  function automatic longint acc32();
    return longint'($signed(if32.res_acc));
  endfunction

  function automatic longint acc16();
    return longint'($signed(if16.res_acc));
  endfunction

  task automatic run_job(input string tag, input int k, input bit gap, input int hold,
                         input longint e32, input bit s32, input longint e16, input bit s16);
    int guard;
    int i;
    bit ph;
    guard = 0;
    while (!if32.cfg_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_cfg_ready"}, longint'(if32.cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_len   = 16'(k);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk({tag, "_busy"}, longint'(if32.busy), 1);
    if (k == 0) begin
      chk({tag, "_zero_no_op_ready"}, longint'(if32.op_ready), 0);
      chk({tag, "_zero_res_valid"}, longint'(if32.res_valid), 1);
    end else begin
      chk({tag, "_op_ready_after_start"}, longint'(if32.op_ready), 1);
      i = 0;
      ph = 1'b0;
      guard = 0;
      while (i < k && guard < 200) begin
        if (gap && ph) begin
          op_valid = 1'b0;
        end else begin
          op_valid = 1'b1;
          op_a = 8'(cur_a[i]);
          op_b = 8'(cur_b[i]);
          if (!if32.op_ready) begin
            bad++;
            total++;
            $display("FAIL %s_beat%0d: op_ready 0 expected 1", tag, i);
          end
          i++;
        end
        ph = !ph;
        guard++;
        @(negedge clk);
      end
      op_valid = 1'b0;
      chk({tag, "_beats_done"}, longint'(i), longint'(k));
      chk({tag, "_drain_no_valid"}, longint'(if32.res_valid), 0);
      @(negedge clk);
      chk({tag, "_done_valid"}, longint'(if32.res_valid), 1);
    end
    chk({tag, "_acc32"}, acc32(), e32);
    chk({tag, "_sat32"}, longint'(if32.res_sat), longint'(s32));
    chk({tag, "_acc16"}, acc16(), e16);
    chk({tag, "_sat16"}, longint'(if16.res_sat), longint'(s16));
    // Hold the result: stray cfg/op pulses must be ignored.
    for (int h = 0; h < hold; h++) begin
      cfg_valid = (h % 2 == 0);
      cfg_len   = 16'd3;
      op_valid  = 1'b1;
      op_a      = 8'd77;
      op_b      = 8'd77;
      @(negedge clk);
      chk({tag, "_hold_acc32"}, acc32(), e32);
      chk({tag, "_hold_acc16"}, acc16(), e16);
      chk({tag, "_hold_cfg_ready"}, longint'(if32.cfg_ready), 0);
      chk({tag, "_hold_valid"}, longint'(if32.res_valid), 1);
    end
    cfg_valid = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_cfg_ready_after_res"}, longint'(if32.cfg_ready), 1);
    chk({tag, "_res_valid_dropped"}, longint'(if32.res_valid), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, longint'(if32.cfg_ready), 1);
    chk({tag, "_op_ready"}, longint'(if32.op_ready), 0);
    chk({tag, "_res_valid"}, longint'(if32.res_valid), 0);
    chk({tag, "_res_acc"}, acc32(), 0);
    chk({tag, "_res_sat"}, longint'(if32.res_sat), 0);
    chk({tag, "_busy"}, longint'(if32.busy), 0);
    chk({tag, "_res_acc16"}, acc16(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint m32, m16;
    bit     q32, q16;
    int     k;
    total     = 0;
    bad       = 0;
    rstnn     = 1'b0;
    cfg_valid = 1'b0;
    cfg_len   = 16'd0;
    op_valid  = 1'b0;
    op_a      = 8'd0;
    op_b      = 8'd0;
    res_ready = 1'b0;

    vecs[0] = '{4, '{1, -2, 3, 127, 0, 0, 0, 0}, '{5, 6, -7, 127, 0, 0, 0, 0}, 1'b0, 0,
                16101, 1'b0, 16101, 1'b0};
    vecs[1] = '{0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 0,
                0, 1'b0, 0, 1'b0};
    vecs[2] = '{3, '{127, 127, 127, 0, 0, 0, 0, 0}, '{127, 127, 127, 0, 0, 0, 0, 0}, 1'b0, 0,
                48387, 1'b0, 32767, 1'b1};
    vecs[3] = '{3, '{127, 127, 127, 0, 0, 0, 0, 0}, '{-128, -128, -128, 0, 0, 0, 0, 0}, 1'b0, 0,
                -48768, 1'b0, -32768, 1'b1};
    vecs[4] = '{2, '{-128, -128, 0, 0, 0, 0, 0, 0}, '{-128, -128, 0, 0, 0, 0, 0, 0}, 1'b1, 0,
                32768, 1'b0, 32767, 1'b1};
    vecs[5] = '{2, '{100, -3, 0, 0, 0, 0, 0, 0}, '{50, 9, 0, 0, 0, 0, 0, 0}, 1'b0, 5,
                4973, 1'b0, 4973, 1'b0};
    vecs[6] = '{4, '{127, 127, 127, -128, 0, 0, 0, 0}, '{127, 127, 127, 127, 0, 0, 0, 0}, 1'b0, 1,
                32131, 1'b0, 16511, 1'b1};

    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < 8; j++) begin
        cur_a[j] = vecs[v].a[j];
        cur_b[j] = vecs[v].b[j];
      end
      run_job($sformatf("vec%0d", v), vecs[v].k, vecs[v].gap, vecs[v].hold,
              vecs[v].e32, vecs[v].s32, vecs[v].e16, vecs[v].s16);
    end

    // Async reset in the middle of an 8-beat job, after two beats.
    for (int j = 0; j < 8; j++) begin
      cur_a[j] = 10;
      cur_b[j] = 10;
    end
    cfg_valid = 1'b1;
    cfg_len   = 16'd8;
    @(negedge clk);
    cfg_valid = 1'b0;
    op_valid  = 1'b1;
    op_a      = 8'd10;
    op_b      = 8'd10;
    @(negedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    chk("midreset_partial_acc", acc32(), 100);
    #2;
    rstnn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    cur_a[0] = 3;
    cur_b[0] = -4;
    run_job("after_reset", 1, 1'b0, 0, -12, 1'b0, -12, 1'b0);

    // Random jobs against the reference model.
    for (int r = 0; r < 14; r++) begin
      k = int'($urandom_range(1, 12));
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          cur_a[j] = ($urandom_range(0, 1) == 0) ? 127 : -128;
          cur_b[j] = ($urandom_range(0, 1) == 0) ? 127 : -128;
        end else begin
          cur_a[j] = int'($urandom_range(0, 255)) - 128;
          cur_b[j] = int'($urandom_range(0, 255)) - 128;
        end
      end
      model(32, k, m32, q32);
      model(16, k, m16, q16);
      run_job($sformatf("rand%0d", r), k, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), m32, q32, m16, q16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
